pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit for the 5-stage CPU, generalised to NSTAGE stages. It replaces the single global stall with per-stage hold and flush vectors. It tracks destination-register metadata for every stage from EX onward, detects load-use hazards, drives operand-forwarding selects, sequences multi-cycle EX operations and applies branch/ret flushes. It sits beside the IF…WB slices and drives their stage-register enables.

---
 rtl/pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline control unit for an NSTAGE-deep in-order pipeline
//               (stage 0 = IF, 1 = ID, 2 = EX, NSTAGE-1 = WB). It tracks
//               destination metadata from EX onward and produces per-stage
//               hold/bubble controls, operand-forwarding selects, multi-cycle
//               EX sequencing, branch flushes and halt/drain status.
// Ports       : clk, rst (async, active high)
//               hlt                 - stop fetch and drain the pipeline
//               id_*                - decoded ID-stage instruction fields
//               br_taken            - taken branch resolved at BR_STAGE
//               stall_vec/flush_vec - per-stage hold / load-bubble controls
//               fwd_a/fwd_b         - forward source stage (0 = register file)
//               mc_busy             - multi-cycle op occupying EX
//               halted              - hlt asserted and stages 1.. are empty
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int NSTAGE   = 5,
  parameter int RA_W     = 4,
  parameter int BR_STAGE = 3,
  parameter int LD_STAGE = 2,
  parameter int MC_W     = 4,
  parameter int SEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wen,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_load,
  input  logic              id_mc,
  input  logic [MC_W-1:0]   id_mc_cycles,
  input  logic              br_taken,
  output logic [NSTAGE-1:0] stall_vec,
  output logic [NSTAGE-1:0] flush_vec,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              mc_busy,
  output logic              halted
);

  // Tracked entries for stages 2..NSTAGE-1
  logic [NSTAGE-1:2]           r_v;
  logic [NSTAGE-1:2]           r_wen;
  logic [NSTAGE-1:2]           r_load;
  logic [NSTAGE-1:2][RA_W-1:0] r_rd;
  logic [MC_W-1:0]             r_mc_cnt;

  // View of entry s-1 as seen by stage s (stage 1 comes straight from ID)
  logic [NSTAGE-1:2]           w_pv;
  logic [NSTAGE-1:2]           w_pwen;
  logic [NSTAGE-1:2]           w_pload;
  logic [NSTAGE-1:2][RA_W-1:0] w_prd;

  logic            w_load_use;
  logic            w_mc_adv;
  logic [MC_W-1:0] w_mc_init;

  function automatic logic f_match(input logic v, input logic wen,
                                   input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] r);
    return v & wen & (rd == r) & (r != '0);
  endfunction

  always_comb begin
    w_pv    = '0;
    w_pwen  = '0;
    w_pload = '0;
    w_prd   = '0;
    w_pv[2]    = id_valid;
    w_pwen[2]  = id_wen;
    w_pload[2] = id_load;
    w_prd[2]   = id_rd;
    for (int s = 3; s < NSTAGE; s++) begin
      w_pv[s]    = r_v[s-1];
      w_pwen[s]  = r_wen[s-1];
      w_pload[s] = r_load[s-1];
      w_prd[s]   = r_rd[s-1];
    end
  end

  // Forwarding: scan oldest to youngest so the youngest producer wins.
  // A load still sitting in LD_STAGE has no data yet, so it cannot forward.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int s = NSTAGE - 1; s >= 2; s--) begin
      if (!((s == LD_STAGE) && r_load[s])) begin
        if (id_rs_used && f_match(r_v[s], r_wen[s], r_rd[s], id_rs))
          fwd_a = SEL_W'(s);
        if (id_rt_used && f_match(r_v[s], r_wen[s], r_rd[s], id_rt))
          fwd_b = SEL_W'(s);
      end
    end
  end

  assign w_load_use = id_valid & r_load[LD_STAGE] &
      ((id_rs_used & f_match(r_v[LD_STAGE], r_wen[LD_STAGE], r_rd[LD_STAGE], id_rs)) |
       (id_rt_used & f_match(r_v[LD_STAGE], r_wen[LD_STAGE], r_rd[LD_STAGE], id_rt)));

  assign mc_busy = (r_mc_cnt != '0);

  // Priority: branch > multi-cycle > load-use > halt. Controls are forced
  // idle while reset is held so the stage slices see no spurious enables.
  always_comb begin
    stall_vec = '0;
    flush_vec = '0;
    if (!rst) begin
      if (br_taken) begin
        for (int i = 0; i < BR_STAGE; i++) flush_vec[i] = 1'b1;
      end else if (mc_busy) begin
        stall_vec[2:0] = '1;
        flush_vec[3]   = 1'b1;
      end else if (w_load_use) begin
        stall_vec[1:0] = '1;
        flush_vec[2]   = 1'b1;
      end else if (hlt) begin
        stall_vec[0] = 1'b1;
        flush_vec[1] = 1'b1;
      end
    end
  end

  assign halted = hlt & (rst | (~id_valid & ~(|r_v)));

  // A multi-cycle op starts counting only when it actually enters EX
  assign w_mc_adv  = id_valid & id_mc & ~stall_vec[2] & ~flush_vec[2];
  assign w_mc_init = (id_mc_cycles == '0) ? '0 : (id_mc_cycles - MC_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mc_cnt <= '0;
    end else if (br_taken && (BR_STAGE > 2)) begin
      r_mc_cnt <= '0;
    end else if (w_mc_adv) begin
      r_mc_cnt <= w_mc_init;
    end else if (r_mc_cnt != '0) begin
      r_mc_cnt <= r_mc_cnt - MC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v    <= '0;
      r_wen  <= '0;
      r_load <= '0;
      r_rd   <= '0;
    end else begin
      for (int s = 2; s < NSTAGE; s++) begin
        if (flush_vec[s]) begin
          r_v[s] <= 1'b0;
        end else if (!stall_vec[s]) begin
          r_v[s]    <= w_pv[s];
          r_wen[s]  <= w_pwen[s];
          r_load[s] <= w_pload[s];
          r_rd[s]   <= w_prd[s];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed scoreboard bench for pipe_hazard_ctrl. The driver
//               pushes one expected output record per cycle; a monitor pops
//               and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int NSTAGE = 5;
  localparam int RA_W   = 4;
  localparam int MC_W   = 4;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              hlt;
  logic              id_valid;
  logic [RA_W-1:0]   id_rs, id_rt, id_rd;
  logic              id_rs_used, id_rt_used, id_wen, id_load, id_mc;
  logic [MC_W-1:0]   id_mc_cycles;
  logic              br_taken;
  logic [NSTAGE-1:0] stall_vec, flush_vec;
  logic [SEL_W-1:0]  fwd_a, fwd_b;
  logic              mc_busy, halted;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NSTAGE(NSTAGE), .RA_W(RA_W), .BR_STAGE(3), .LD_STAGE(2),
    .MC_W(MC_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst), .hlt(hlt), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_wen(id_wen), .id_rd(id_rd),
    .id_load(id_load), .id_mc(id_mc), .id_mc_cycles(id_mc_cycles),
    .br_taken(br_taken), .stall_vec(stall_vec), .flush_vec(flush_vec),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_busy(mc_busy), .halted(halted)
  );

  typedef struct packed {
    logic [95:0]       nm;
    logic [NSTAGE-1:0] st;
    logic [NSTAGE-1:0] fl;
    logic [SEL_W-1:0]  fa;
    logic [SEL_W-1:0]  fb;
    logic              busy;
    logic              hal;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_out(input logic [95:0] nm, input logic [NSTAGE-1:0] st,
                            input logic [NSTAGE-1:0] fl, input logic [SEL_W-1:0] fa,
                            input logic [SEL_W-1:0] fb, input logic busy,
                            input logic hal);
    exp_t e;
    e.nm = nm; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb;
    e.busy = busy; e.hal = hal;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_wen = 0; id_rd = 0; id_load = 0; id_mc = 0; id_mc_cycles = 0;
    br_taken = 0; hlt = 0;
  endtask

  task automatic set_id(input logic v, input logic [RA_W-1:0] rs, input logic rsu,
                        input logic [RA_W-1:0] rt, input logic rtu, input logic wen,
                        input logic [RA_W-1:0] rd, input logic ld, input logic mc,
                        input logic [MC_W-1:0] cyc);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wen = wen; id_rd = rd; id_load = ld; id_mc = mc; id_mc_cycles = cyc;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      idle();
      expect_out("drain", 5'b00000, 5'b00000, 0, 0, 0, 0);
    end
  endtask

  // Monitor: one comparison per falling edge whenever an expectation is queued
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (stall_vec !== e.st || flush_vec !== e.fl || fwd_a !== e.fa ||
            fwd_b !== e.fb || mc_busy !== e.busy || halted !== e.hal) begin
          n_errors++;
          $display("FAIL %0s @%0t: got stall=%b flush=%b fa=%0d fb=%0d busy=%b halted=%b; want stall=%b flush=%b fa=%0d fb=%0d busy=%b halted=%b",
                   e.nm, $time, stall_vec, flush_vec, fwd_a, fwd_b, mc_busy, halted,
                   e.st, e.fl, e.fa, e.fb, e.busy, e.hal);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : drv
    rst = 1;
    idle();

    // Reset state
    tick();                expect_out("rst",     5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); hlt = 1;       expect_out("rst_hlt", 5'b00000, 5'b00000, 0, 0, 0, 1);
    tick(); rst = 0; hlt = 0;
                           expect_out("rst_rel", 5'b00000, 5'b00000, 0, 0, 0, 0);

    // Load-use stall then forwarding from MEM / WB
    tick(); set_id(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
                           expect_out("ld_issue", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 3, 1, 4, 1, 1, 6, 0, 0, 0);
                           expect_out("ld_use",   5'b00011, 5'b00100, 0, 0, 0, 0);
    tick();                expect_out("ld_fwd",   5'b00000, 5'b00000, 3, 0, 0, 0);
    tick(); set_id(1, 3, 1, 6, 1, 0, 0, 0, 0, 0);
                           expect_out("fwd_wb",   5'b00000, 5'b00000, 4, 2, 0, 0);
    tick(); set_id(0, 6, 0, 6, 1, 0, 0, 0, 0, 0);
                           expect_out("rs_unused", 5'b00000, 5'b00000, 0, 3, 0, 0);
    drain(3);

    // Youngest producer wins; r0 never forwards
    tick(); set_id(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
                           expect_out("w5a",    5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
                           expect_out("w7",     5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
                           expect_out("w5b",    5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 5, 1, 0, 1, 0, 0, 0, 0, 0);
                           expect_out("young",  5'b00000, 5'b00000, 2, 0, 0, 0);
    tick(); set_id(1, 5, 1, 7, 1, 0, 0, 0, 0, 0);
                           expect_out("mem_wb", 5'b00000, 5'b00000, 3, 4, 0, 0);
    tick(); set_id(1, 5, 1, 0, 0, 1, 0, 0, 0, 0);
                           expect_out("wb_r5",  5'b00000, 5'b00000, 4, 0, 0, 0);
    tick(); set_id(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
                           expect_out("r0",     5'b00000, 5'b00000, 0, 0, 0, 0);
    drain(3);

    // Multi-cycle op of 4 cycles: busy for 3
    tick(); set_id(1, 0, 0, 0, 0, 1, 9, 0, 1, 4);
                           expect_out("mc_issue", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
                           expect_out("mc_busy1", 5'b00111, 5'b01000, 2, 0, 1, 0);
    tick();                expect_out("mc_busy2", 5'b00111, 5'b01000, 2, 0, 1, 0);
    tick();                expect_out("mc_busy3", 5'b00111, 5'b01000, 2, 0, 1, 0);
    tick();                expect_out("mc_done",  5'b00000, 5'b00000, 2, 0, 0, 0);
    tick(); set_id(0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
                           expect_out("mc_adv",   5'b00000, 5'b00000, 3, 0, 0, 0);
    drain(3);

    // Cycle count of 0 behaves as 1: never busy
    tick(); set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                           expect_out("mc_zero",  5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); idle();        expect_out("mc_zero2", 5'b00000, 5'b00000, 0, 0, 0, 0);
    drain(3);

    // Branch during multi-cycle with a load-use hazard present
    tick(); set_id(1, 0, 0, 0, 0, 1, 10, 1, 1, 3);
                           expect_out("mcld_iss", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
                           expect_out("mc_ld",    5'b00111, 5'b01000, 0, 0, 1, 0);
    tick(); br_taken = 1;  expect_out("br",       5'b00000, 5'b00111, 0, 0, 1, 0);
    tick(); br_taken = 0;  expect_out("post_br",  5'b00000, 5'b00000, 3, 0, 0, 0);
    drain(3);

    // Halt and drain
    tick(); set_id(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
                           expect_out("hA",     5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
                           expect_out("hB",     5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); hlt = 1;
                           expect_out("hlt0",   5'b00001, 5'b00010, 0, 0, 0, 0);
    tick(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                           expect_out("hlt1",   5'b00001, 5'b00010, 0, 0, 0, 0);
    tick();                expect_out("hlt2",   5'b00001, 5'b00010, 0, 0, 0, 0);
    tick();                expect_out("hlt3",   5'b00001, 5'b00010, 0, 0, 0, 0);
    tick();                expect_out("halted", 5'b00001, 5'b00010, 0, 0, 0, 1);
    tick(); hlt = 0;       expect_out("unhalt", 5'b00000, 5'b00000, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a multi-cycle stall
    tick(); set_id(1, 0, 0, 0, 0, 1, 11, 0, 1, 5);
                           expect_out("mc5_iss",  5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); set_id(1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
                           expect_out("mc_rst0",  5'b00111, 5'b01000, 2, 0, 1, 0);
    tick(); rst = 1;       expect_out("arst",     5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); rst = 0;       expect_out("arst_rel", 5'b00000, 5'b00000, 0, 0, 0, 0);
    tick(); idle();        expect_out("final",    5'b00000, 5'b00000, 0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
